// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_pkg                                                |
// | Brief   : Shared types and constants for the UART receiver slice.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_rx_pkg;

    localparam int c_FRAME_BITS          = 8;
    localparam int c_CLKS_PER_BIT_DEFAULT = 10;
    localparam int c_TIMER_W             = 4;
    localparam int c_CNT_W               = $clog2(c_FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/flex_stp_sr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : flex_stp_sr                                                |
// | Brief   : Parameterised serial-to-parallel shift register.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flex_stp_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] r_data;
    logic [NUM_BITS-1:0] w_next;

    // SHIFT_MSB = 0 enters new bits at the top, so the first bit ends up in bit 0.
    generate
        if (SHIFT_MSB) begin : g_shift_msb
            assign w_next = {r_data[NUM_BITS-2:0], serial_in};
        end else begin : g_shift_lsb
            assign w_next = {serial_in, r_data[NUM_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data <= '1;
        end else if (shift_enable) begin
            r_data <= w_next;
        end
    end

    assign parallel_out = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_rx_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : uart_rx_block                                              |
// | Brief   : 8N1 UART receiver with data-ready, overrun, framing flags. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_block
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    serial_in,
    input  logic                    data_read,
    output logic [c_FRAME_BITS-1:0] rx_data,
    output logic                    data_ready,
    output logic                    overrun_error,
    output logic                    framing_error
);

    localparam logic [c_TIMER_W-1:0] c_HALF_LOAD = c_TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TIMER_W-1:0] c_BIT_LOAD  = c_TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]   c_LAST_BIT  = c_CNT_W'(c_FRAME_BITS - 1);

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_sin_d;
    rx_state_t               r_state;
    rx_state_t               w_state_next;
    logic [c_TIMER_W-1:0]    r_timer;
    logic [c_TIMER_W-1:0]    w_timer_next;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic [c_CNT_W-1:0]      w_bit_cnt_next;
    logic                    w_tick;
    logic                    w_start_edge;
    logic                    w_shift;
    logic                    w_load;
    logic                    w_set_fe;
    logic                    w_clr_fe;
    logic [c_FRAME_BITS-1:0] w_shift_byte;

    assign w_tick       = (r_timer == '0);
    assign w_start_edge = r_sin_d & ~r_sync2;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sin_d   <= 1'b1;
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_sin_d   <= r_sync2;
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    // Timer is loaded for the half-bit to mid-start, then a full bit per sample.
    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_cnt_next = r_bit_cnt;
        w_shift        = 1'b0;
        w_load         = 1'b0;
        w_set_fe       = 1'b0;
        w_clr_fe       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_state_next   = START;
                    w_timer_next   = c_HALF_LOAD;
                    w_bit_cnt_next = '0;
                    w_clr_fe       = 1'b1;
                end
            end
            START: begin
                if (!w_tick) begin
                    w_timer_next = r_timer - 1'b1;
                end else if (r_sync2) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DATA;
                    w_timer_next = c_BIT_LOAD;
                end
            end
            DATA: begin
                if (!w_tick) begin
                    w_timer_next = r_timer - 1'b1;
                end else begin
                    w_shift      = 1'b1;
                    w_timer_next = c_BIT_LOAD;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_next   = STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!w_tick) begin
                    w_timer_next = r_timer - 1'b1;
                end else begin
                    w_state_next = IDLE;
                    w_timer_next = '0;
                    w_load       = r_sync2;
                    w_set_fe     = ~r_sync2;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    flex_stp_sr #(
        .NUM_BITS  (c_FRAME_BITS),
        .SHIFT_MSB (1'b0)
    ) u_shift (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (w_shift),
        .serial_in    (r_sync2),
        .parallel_out (w_shift_byte)
    );

    // A load wins over a simultaneous acknowledge; the acknowledge suppresses overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= 8'hFF;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data       <= w_shift_byte;
                data_ready    <= 1'b1;
                overrun_error <= data_ready & ~data_read;
            end else if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (w_clr_fe) begin
                framing_error <= 1'b0;
            end else if (w_set_fe) begin
                framing_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_uart_rx_block                                           |
// | Brief   : Directed frames against a cycle-number receiver model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_block;

    localparam int C = 10;
    localparam int H = C / 2;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int rise_cyc = -1;
    int n0;
    logic chk_en  = 1'b0;
    logic dr_prev = 1'b0;

    // Model: line history, active frame with absolute sample cycle numbers.
    logic       h1, h2, h3;
    logic       m_active;
    int         m_next;
    int         m_k;
    logic [7:0] m_byte;
    logic [7:0] m_rx;
    logic       m_dr, m_ov, m_fe;
    logic       m_loaded;

    uart_rx_block #(.CLKS_PER_BIT(C)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
            m_active = 1'b0; m_next = 0; m_k = 0; m_byte = 8'hFF;
            m_rx = 8'hFF; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        end else begin
            m_loaded = 1'b0;
            // h2 is the line as seen this cycle after the two-flop delay, h3 the cycle before.
            if (!m_active) begin
                if (h3 && !h2) begin
                    m_active = 1'b1; m_k = 0; m_next = cyc + H; m_fe = 1'b0;
                end
            end else if (cyc == m_next) begin
                if (m_k == 0) begin
                    if (h2) m_active = 1'b0;
                    else begin m_k = 1; m_next = m_next + C; end
                end else if (m_k <= 8) begin
                    m_byte[m_k-1] = h2; m_k = m_k + 1; m_next = m_next + C;
                end else begin
                    m_active = 1'b0;
                    if (h2) begin
                        m_ov = m_dr && !data_read;
                        m_rx = m_byte; m_dr = 1'b1; m_loaded = 1'b1;
                    end else begin
                        m_fe = 1'b1;
                    end
                end
            end
            if (!m_loaded && data_read && m_dr) begin
                m_dr = 1'b0; m_ov = 1'b0;
            end
            h3 = h2; h2 = h1; h1 = serial_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if ({rx_data, data_ready, overrun_error, framing_error} !== {m_rx, m_dr, m_ov, m_fe}) begin
                n_err++;
                $display("FAIL model_cycle_%0d: got rx=%h dr=%b ov=%b fe=%b, expected rx=%h dr=%b ov=%b fe=%b",
                         cyc, rx_data, data_ready, overrun_error, framing_error, m_rx, m_dr, m_ov, m_fe);
            end
            if (data_ready && !dr_prev) rise_cyc = cyc;
            dr_prev = data_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int nslots);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nslots; i++) begin
            serial_in = f[i];
            repeat (C) tick();
        end
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        tick();
    endtask

    initial begin
        n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_rx_data", rx_data, 8'hFF);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_overrun", overrun_error, 1'b0);
        chk("rst_framing", framing_error, 1'b0);
        n_rst = 1'b1;
        repeat (5) tick();

        // 0xA5: two synchronizer cycles plus 96 after the start edge
        n0 = cyc;
        send_frame(8'hA5, 1'b1, 10);
        repeat (3) tick();
        chk("a5_latency", rise_cyc - n0, 98);
        chk("a5_rx_data", rx_data, 8'hA5);
        chk("a5_framing", framing_error, 1'b0);
        read_pulse();

        // back-to-back 0x3C then 0x81 without acknowledge
        send_frame(8'h3C, 1'b1, 10);
        send_frame(8'h81, 1'b1, 10);
        repeat (3) tick();
        chk("ovr_rx_data", rx_data, 8'h81);
        chk("ovr_flag", overrun_error, 1'b1);
        chk("ovr_ready", data_ready, 1'b1);
        read_pulse();
        chk("ack_ready", data_ready, 1'b0);
        chk("ack_overrun", overrun_error, 1'b0);

        // 3-cycle glitch then 0x0F
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        chk("glitch_rx_data", rx_data, 8'h81);
        chk("glitch_ready", data_ready, 1'b0);
        send_frame(8'h0F, 1'b1, 10);
        repeat (3) tick();
        chk("0f_rx_data", rx_data, 8'h0F);
        chk("0f_ready", data_ready, 1'b1);

        // 0x55 with a zero stop bit
        send_frame(8'h55, 1'b0, 10);
        serial_in = 1'b1;
        repeat (20) tick();
        chk("fe_set", framing_error, 1'b1);
        chk("fe_rx_data", rx_data, 8'h0F);
        chk("fe_ready", data_ready, 1'b1);

        // 0x7E loaded in the same cycle as an acknowledge of the pending 0x0F
        n0 = cyc;
        fork
            send_frame(8'h7E, 1'b1, 10);
            begin
                repeat (5) tick();
                chk("fe_clr_on_start", framing_error, 1'b0);
                repeat (92) tick();
                data_read = 1'b1;
                tick();
                data_read = 1'b0;
            end
        join
        repeat (3) tick();
        chk("7e_rx_data", rx_data, 8'h7E);
        chk("7e_ready", data_ready, 1'b1);
        chk("7e_overrun", overrun_error, 1'b0);

        // reset after data bit 4, then 0xC3
        send_frame(8'h99, 1'b1, 6);
        n_rst = 1'b0;
        serial_in = 1'b1;
        tick();
        chk("mid_rst_rx_data", rx_data, 8'hFF);
        chk("mid_rst_ready", data_ready, 1'b0);
        tick();
        n_rst = 1'b1;
        repeat (10) tick();
        send_frame(8'hC3, 1'b1, 10);
        repeat (5) tick();
        chk("c3_rx_data", rx_data, 8'hC3);
        chk("c3_ready", data_ready, 1'b1);
        chk("c3_framing", framing_error, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
